// File: rtl/fft8_frame_sched_pkg.sv
// Shared types and helpers for the FFT8 frame scheduler: widths, tag struct,
// ceiling log2 and the round-robin pick.
package fft8_sched_pkg;

  localparam int DW      = 24;
  localparam int FRAME_W = 16 * DW;

  // Always at least one bit so single-entry ranges stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Channel field is sized for the largest supported channel count (4).
  typedef struct packed {
    logic       vld;
    logic [1:0] chan;
  } tag_t;

  // One-hot grant for the first set bit at or after ptr, wrapping modulo n.
  function automatic logic [3:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr,
                                         input int n);
    logic [3:0] grant;
    logic [1:0] sel;
    int         idx;
    grant = '0;
    for (int k = n - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      sel = 2'(idx);
      if (valid[sel]) grant = 4'b0001 << sel;
    end
    return grant;
  endfunction

endpackage

// File: rtl/fft8_frame_sched_if.sv
// Requester and result-consumer handshake bundle for the FFT8 frame scheduler.
interface fft8_frame_sched_if
  import fft8_sched_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DW     = fft8_sched_pkg::DW
);
  localparam int FW = 16 * DW;
  localparam int CW = clog2(NUM_CH);

  logic [NUM_CH-1:0]    ch_valid;
  logic [NUM_CH-1:0]    ch_ready;
  logic [NUM_CH*FW-1:0] ch_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [CW-1:0]        res_chan;
  logic [FW-1:0]        res_y;
  logic [DW-1:0]        res_power;

  modport master (
    output ch_valid, ch_data, res_ready,
    input  ch_ready, res_valid, res_chan, res_y, res_power
  );

  modport slave (
    input  ch_valid, ch_data, res_ready,
    output ch_ready, res_valid, res_chan, res_y, res_power
  );

endinterface

// File: rtl/fft8_res_fifo.sv
// First-word fall-through result FIFO; head reads as zero while empty.
module fft8_res_fifo
  import fft8_sched_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int NW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [NW-1:0] count,
  output logic          ovf
);
  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == NW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & ~do_push;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fft8_frame_sched.sv
// Round-robin frame scheduler sharing one pipelined FFT8 between NUM_CH requesters,
// with credit-based issue so every in-flight frame has a guaranteed result slot.
module fft8_frame_sched
  import fft8_sched_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LAT    = 9,
  parameter int DEPTH  = 4,
  parameter int DW     = fft8_sched_pkg::DW
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cfg_enable,
  input  logic [NUM_CH-1:0]   cfg_half,
  fft8_frame_sched_if.slave   bus,
  output logic                fft_en,
  output logic [16*DW-1:0]    fft_x,
  output logic                fft_sel,
  input  logic                fft_valid,
  input  logic [16*DW-1:0]    fft_y,
  input  logic [DW-1:0]       fft_power,
  output logic                busy,
  output logic                err
);
  localparam int FW = 16 * DW;
  localparam int CW = clog2(NUM_CH);
  localparam int NW = clog2(DEPTH + 1);
  localparam int EW = CW + FW + DW;

  logic          up;
  logic [1:0]    rr_ptr, gnt_idx, issued_chan;
  logic [3:0]    valid4, half4, grant4;
  logic [NW-1:0] in_flight, fifo_count;
  logic          can_issue, issue, done, push, pop, ovf, empty;
  logic [FW-1:0] gnt_data;
  logic [EW-1:0] fifo_din, fifo_dout;
  tag_t          tag [LAT];

  always_comb begin
    valid4 = '0;
    half4  = '0;
    valid4[NUM_CH-1:0] = bus.ch_valid;
    half4[NUM_CH-1:0]  = cfg_half;
  end

  // Pushes move a credit from in_flight to the FIFO, so the sum covers them.
  assign can_issue = up & cfg_enable & ((int'(in_flight) + int'(fifo_count)) < DEPTH);

  always_comb begin
    grant4   = can_issue ? rr_pick(valid4, rr_ptr, NUM_CH) : 4'b0000;
    gnt_idx  = 2'd0;
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant4[i]) begin
        gnt_idx  = 2'(i);
        gnt_data = bus.ch_data[i*FW +: FW];
      end
    end
  end

  assign issue        = |grant4;
  assign bus.ch_ready = grant4[NUM_CH-1:0];

  // Issue stage: handshake -> registered strobe and frame toward the FFT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up          <= 1'b0;
      rr_ptr      <= '0;
      fft_en      <= 1'b0;
      fft_x       <= '0;
      issued_chan <= '0;
    end else begin
      up     <= 1'b1;
      fft_en <= issue;
      if (issue) begin
        rr_ptr      <= (int'(gnt_idx) == NUM_CH - 1) ? 2'd0 : gnt_idx + 2'd1;
        fft_x       <= gnt_data;
        issued_chan <= gnt_idx;
      end
    end
  end

  // Tag stages: mirror the FFT latency so each result knows its channel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) tag[k] <= '0;
    end else begin
      tag[0] <= '{vld: fft_en, chan: issued_chan};
      for (int k = 1; k < LAT; k++) tag[k] <= tag[k-1];
    end
  end

  // Completion stage: capture into the result FIFO
  assign done     = tag[LAT-1].vld;
  assign push     = done & fft_valid;
  assign fft_sel  = done & half4[tag[LAT-1].chan];
  assign pop      = ~empty & bus.res_ready;
  assign fifo_din = {tag[LAT-1].chan[CW-1:0], fft_y, fft_power};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_flight <= '0;
      err       <= 1'b0;
    end else begin
      case ({issue, done})
        2'b10:   in_flight <= in_flight + NW'(1);
        2'b01:   in_flight <= in_flight - NW'(1);
        default: ;
      endcase
      if ((fft_valid ^ done) | ovf) err <= 1'b1;
    end
  end

  fft8_res_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (empty),
    .count (fifo_count),
    .ovf   (ovf)
  );

  assign bus.res_valid = ~empty;
  assign {bus.res_chan, bus.res_y, bus.res_power} = fifo_dout;
  assign busy = (in_flight != '0) | ~empty;

endmodule

// File: tb/tb_fft8_frame_sched.sv
// Directed bench for fft8_frame_sched with a behavioural stand-in FFT and a result scoreboard.
module tb_fft8_frame_sched;
  import fft8_sched_pkg::*;

  localparam int NUM_CH = 2;
  localparam int LAT    = 9;
  localparam int DEPTH  = 4;
  localparam int FW     = 16 * DW;

  typedef struct {
    logic [1:0]    chan;
    logic [FW-1:0] y;
    logic [DW-1:0] p;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn, cfg_enable, inject;
  logic [NUM_CH-1:0] cfg_half;
  logic              fft_en, fft_sel, fft_valid, busy, err;
  logic [FW-1:0]     fft_x, fft_y;
  logic [DW-1:0]     fft_power;

  int   n_vec = 0, n_err = 0, n_hs = 0;
  logic alt_chk = 1'b0, have_last = 1'b0;
  logic [1:0] last_ch;
  exp_t sb[$];
  logic [1:0] iq[$];
  logic [FW-1:0] mx [LAT];
  logic          mv [LAT];

  logic [NUM_CH-1:0] mon_hs;
  logic [1:0]        mon_c;
  logic [FW-1:0]     mon_fr;
  exp_t              mon_e;

  fft8_frame_sched_if #(.NUM_CH(NUM_CH), .DW(DW)) bus ();

  fft8_frame_sched #(.NUM_CH(NUM_CH), .LAT(LAT), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_enable (cfg_enable),
    .cfg_half   (cfg_half),
    .bus        (bus),
    .fft_en     (fft_en),
    .fft_x      (fft_x),
    .fft_sel    (fft_sel),
    .fft_valid  (fft_valid),
    .fft_y      (fft_y),
    .fft_power  (fft_power),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact 8-point DFT for frames whose only non-zero samples are x0 and x4.
  function automatic logic [FW-1:0] dft_model(input logic [FW-1:0] x);
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic [FW-1:0] y;
    a_re = x[0 +: DW];
    a_im = x[DW +: DW];
    b_re = x[8*DW +: DW];
    b_im = x[9*DW +: DW];
    for (int k = 0; k < 8; k++) begin
      y[2*k*DW +: DW]     = (k % 2 == 0) ? a_re + b_re : a_re - b_re;
      y[(2*k+1)*DW +: DW] = (k % 2 == 0) ? a_im + b_im : a_im - b_im;
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] power_model(input logic [FW-1:0] y, input logic half);
    logic signed [DW-1:0]     re, im;
    logic signed [2*DW-1:0]   sq;
    logic signed [2*DW+3:0]   acc;
    int b0;
    acc = '0;
    b0  = half ? 0 : 4;
    for (int b = b0; b < b0 + 4; b++) begin
      re  = y[2*b*DW +: DW];
      im  = y[(2*b+1)*DW +: DW];
      sq  = re * re;
      acc = acc + sq;
      sq  = im * im;
      acc = acc + sq;
    end
    return acc[DW-1:0];
  endfunction

  function automatic logic [FW-1:0] mk_frame(input logic [DW-1:0] x0_re, input logic [DW-1:0] x4_re);
    logic [FW-1:0] f;
    f = '0;
    f[0 +: DW]    = x0_re;
    f[8*DW +: DW] = x4_re;
    return f;
  endfunction

  // Stand-in FFT: LAT-deep pipeline, power taken from the half the scheduler selects.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) mv[k] <= 1'b0;
    end else begin
      mv[0] <= fft_en;
      mx[0] <= fft_x;
      for (int k = 1; k < LAT; k++) begin
        mv[k] <= mv[k-1];
        mx[k] <= mx[k-1];
      end
    end
  end

  assign fft_valid = mv[LAT-1] | inject;
  assign fft_y     = dft_model(mx[LAT-1]);
  assign fft_power = power_model(fft_y, fft_sel);

  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      iq.delete();
      have_last = 1'b0;
    end else begin
      mon_hs = bus.ch_valid & bus.ch_ready;
      if (mon_hs != '0) begin
        mon_c = mon_hs[1] ? 2'd1 : 2'd0;
        chk("grant_onehot", FW'($onehot(mon_hs)), FW'(1));
        chk("credit", FW'(sb.size() < DEPTH), FW'(1));
        if (alt_chk && have_last) chk("rr_order", FW'(mon_c), FW'(last_ch ^ 2'd1));
        last_ch   = mon_c;
        have_last = 1'b1;
        mon_fr     = bus.ch_data[mon_c*FW +: FW];
        mon_e.chan = mon_c;
        mon_e.y    = dft_model(mon_fr);
        mon_e.p    = power_model(mon_e.y, cfg_half[mon_c]);
        sb.push_back(mon_e);
        iq.push_back(mon_c);
        n_hs++;
      end
      if (mv[LAT-1]) begin
        if (iq.size() == 0) chk("sel_tag", FW'(1), FW'(0));
        else begin
          mon_c = iq.pop_front();
          chk("fft_sel", FW'(fft_sel), FW'(cfg_half[mon_c]));
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) chk("res_unexpected", FW'(1), FW'(0));
        else begin
          mon_e = sb.pop_front();
          chk("res_chan", FW'(bus.res_chan), FW'(mon_e.chan));
          chk("res_y", bus.res_y, mon_e.y);
          chk("res_power", FW'(bus.res_power), FW'(mon_e.p));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] ones;
    int cyc, base;

    rstn = 1'b0; cfg_enable = 1'b1; cfg_half = 2'b11; inject = 1'b0;
    bus.ch_valid = 2'b11; bus.ch_data = '0; bus.res_ready = 1'b0;
    #12;
    chk("rst_ch_ready", FW'(bus.ch_ready), FW'(0));
    chk("rst_fft_en", FW'(fft_en), FW'(0));
    chk("rst_fft_x", fft_x, FW'(0));
    chk("rst_fft_sel", FW'(fft_sel), FW'(0));
    chk("rst_res_valid", FW'(bus.res_valid), FW'(0));
    chk("rst_res_power", FW'(bus.res_power), FW'(0));
    chk("rst_busy", FW'(busy), FW'(0));
    chk("rst_err", FW'(err), FW'(0));
    bus.ch_valid = 2'b00;
    @(posedge clk); #1;
    rstn = 1'b1;
    tick(2);

    // impulse on ch0: flat spectrum, power 4, result 11 cycles after handshake
    bus.ch_data[0 +: FW] = mk_frame(24'd1, 24'd0);
    bus.ch_valid = 2'b01;
    #1 chk("t1_ready", FW'(bus.ch_ready), FW'(2'b01));
    tick(1);
    bus.ch_valid = 2'b00;
    chk("t1_fft_en_on", FW'(fft_en), FW'(1));
    chk("t1_fft_x", fft_x, mk_frame(24'd1, 24'd0));
    tick(1);
    chk("t1_fft_en_off", FW'(fft_en), FW'(0));
    chk("t1_fft_x_hold", fft_x, mk_frame(24'd1, 24'd0));
    cyc = 2;
    while (!bus.res_valid && cyc < 40) begin
      tick(1);
      cyc++;
    end
    chk("t1_latency", FW'(cyc), FW'(11));
    ones = '0;
    for (int k = 0; k < 8; k++) ones[2*k*DW +: DW] = 24'd1;
    chk("t1_res_chan", FW'(bus.res_chan), FW'(0));
    chk("t1_res_y", bus.res_y, ones);
    chk("t1_res_power", FW'(bus.res_power), FW'(4));
    chk("t1_busy", FW'(busy), FW'(1));
    bus.res_ready = 1'b1;
    tick(1);
    chk("t1_drained", FW'(bus.res_valid), FW'(0));
    chk("t1_idle", FW'(busy), FW'(0));

    // both channels continuously valid: alternating grants, credit-limited
    bus.ch_data[0 +: FW]  = mk_frame(24'h10, 24'd0);
    bus.ch_data[FW +: FW] = mk_frame(24'h20, 24'd3);
    have_last = 1'b0;
    alt_chk   = 1'b1;
    base = n_hs;
    bus.ch_valid = 2'b11;
    tick(60);
    chk("t2_issue_resumes", FW'((n_hs - base) >= 8), FW'(1));
    bus.ch_valid = 2'b00;
    alt_chk = 1'b0;
    tick(25);
    chk("t2_busy_end", FW'(busy), FW'(0));
    chk("t2_all_results", FW'(sb.size()), FW'(0));

    // consumer stalled: exactly DEPTH issues, then ready drops
    bus.res_ready = 1'b0;
    bus.ch_data[0 +: FW] = mk_frame(24'h5, 24'h7);
    base = n_hs;
    bus.ch_valid = 2'b01;
    tick(30);
    chk("t3_issue_count", FW'(n_hs - base), FW'(4));
    chk("t3_ready_low", FW'(bus.ch_ready), FW'(0));
    chk("t3_res_valid", FW'(bus.res_valid), FW'(1));
    chk("t3_err", FW'(err), FW'(0));
    chk("t3_queued", FW'(sb.size()), FW'(4));
    base = n_hs;
    bus.res_ready = 1'b1;
    tick(6);
    chk("t3_resume", FW'(n_hs > base), FW'(1));
    bus.ch_valid = 2'b00;
    tick(25);
    chk("t3_busy_end", FW'(busy), FW'(0));
    chk("t3_all_results", FW'(sb.size()), FW'(0));

    // ch1 selects bins 4-7: sel low at completion, power 4 x 2^2
    bus.res_ready = 1'b0;
    cfg_half = 2'b01;
    bus.ch_data[FW +: FW] = mk_frame(24'd0, 24'd2);
    bus.ch_valid = 2'b10;
    tick(1);
    bus.ch_valid = 2'b00;
    for (cyc = 0; cyc < 20 && !mv[LAT-1]; cyc++) tick(1);
    chk("t4_complete", FW'(mv[LAT-1]), FW'(1));
    chk("t4_fft_sel", FW'(fft_sel), FW'(0));
    chk("t4_fft_power", FW'(fft_power), FW'(16));
    tick(1);
    chk("t4_res_valid", FW'(bus.res_valid), FW'(1));
    chk("t4_res_chan", FW'(bus.res_chan), FW'(1));
    chk("t4_res_power", FW'(bus.res_power), FW'(16));
    bus.res_ready = 1'b1;
    tick(3);
    cfg_half = 2'b11;

    // spurious fft_valid with nothing in flight
    chk("t5_err_before", FW'(err), FW'(0));
    inject = 1'b1;
    tick(1);
    inject = 1'b0;
    chk("t5_err_set", FW'(err), FW'(1));
    chk("t5_fifo_empty", FW'(bus.res_valid), FW'(0));
    chk("t5_busy", FW'(busy), FW'(0));
    tick(3);
    chk("t5_err_sticky", FW'(err), FW'(1));

    // reset with two results queued and two frames in flight
    bus.res_ready = 1'b0;
    bus.ch_data[0 +: FW] = mk_frame(24'h3, 24'd0);
    bus.ch_valid = 2'b01;
    for (cyc = 0; cyc < 20 && !bus.res_valid; cyc++) tick(1);
    tick(1);
    chk("t6_busy_pre", FW'(busy), FW'(1));
    #2 rstn = 1'b0;
    #1;
    chk("t6_ch_ready", FW'(bus.ch_ready), FW'(0));
    chk("t6_fft_en", FW'(fft_en), FW'(0));
    chk("t6_fft_x", fft_x, FW'(0));
    chk("t6_fft_sel", FW'(fft_sel), FW'(0));
    chk("t6_res_valid", FW'(bus.res_valid), FW'(0));
    chk("t6_busy", FW'(busy), FW'(0));
    chk("t6_err", FW'(err), FW'(0));
    bus.ch_valid = 2'b00;
    tick(2);
    rstn = 1'b1;
    base = n_hs;
    tick(15);
    chk("t6_no_stale_res", FW'(bus.res_valid), FW'(0));
    chk("t6_busy_after", FW'(busy), FW'(0));
    chk("t6_no_issue", FW'(n_hs - base), FW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
